// File: rtl/syncram_arbiter.sv
// syncram_arbiter: round-robin arbiter that serialises NREQ requesters onto one single-port synchronous RAM
// Ports: clk/nRST (async active-low); req/req_wen/req_addr/req_wdata per requester (slice i = [i*WORD_W +: WORD_W]);
// ack one-hot completion pulse with rdata for reads; busy when not idle; ren/wen/ramaddr/ramstore/ramload to the RAM.
module syncram_arbiter #(
  parameter int NREQ    = 2,
  parameter int WORD_W  = 32,
  parameter int RAM_LAT = 1
) (
  input  logic                     clk,
  input  logic                     nRST,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          req_wen,
  input  logic [NREQ*WORD_W-1:0]   req_addr,
  input  logic [NREQ*WORD_W-1:0]   req_wdata,
  output logic [NREQ-1:0]          ack,
  output logic [WORD_W-1:0]        rdata,
  output logic                     busy,
  output logic                     ren,
  output logic                     wen,
  output logic [WORD_W-1:0]        ramaddr,
  output logic [WORD_W-1:0]        ramstore,
  input  logic [WORD_W-1:0]        ramload
);
  localparam int IW = $clog2(NREQ);
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] win_q, win_d, rr_q, rr_d, pick, idx;
  logic found, ren_q, ren_d, wen_q, wen_d, wr_q, wr_d;
  logic [2:0] lat_q, lat_d;
  logic [WORD_W-1:0] addr_q, addr_d, store_q, store_d, rdata_q, rdata_d;
  // search upward from the requester after the last winner, wrapping
  always_comb begin
    found = 1'b0;
    pick = rr_q;
    idx = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IW'((int'(rr_q) + k) % NREQ);
      if (!found && req[idx]) begin
        found = 1'b1;
        pick = idx;
      end
    end
  end
  always_comb begin
    state_d = state_q;
    win_d = win_q;
    rr_d = rr_q;
    lat_d = lat_q;
    ren_d = 1'b0;
    wen_d = 1'b0;
    wr_d = wr_q;
    addr_d = addr_q;
    store_d = store_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (found) begin
        win_d = pick;
        wr_d = req_wen[pick];
        ren_d = !req_wen[pick];
        wen_d = req_wen[pick];
        addr_d = req_addr[pick*WORD_W +: WORD_W];
        store_d = req_wen[pick] ? req_wdata[pick*WORD_W +: WORD_W] : store_q;
        state_d = ACCESS;
      end
      ACCESS: begin
        state_d = (wr_q || RAM_LAT == 1) ? RESP : WAIT;
        lat_d = (wr_q || RAM_LAT == 1) ? lat_q : 3'(RAM_LAT - 1);
      end
      WAIT: begin
        lat_d = lat_q - 3'd1;
        state_d = (lat_q == 3'd1) ? RESP : WAIT;
      end
      RESP: begin
        rr_d = win_q;
        rdata_d = wr_q ? rdata_q : ramload;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      win_q <= '0;
      rr_q <= IW'(NREQ - 1);
      lat_q <= '0;
      ren_q <= 1'b0;
      wen_q <= 1'b0;
      wr_q <= 1'b0;
      addr_q <= '0;
      store_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      win_q <= win_d;
      rr_q <= rr_d;
      lat_q <= lat_d;
      ren_q <= ren_d;
      wen_q <= wen_d;
      wr_q <= wr_d;
      addr_q <= addr_d;
      store_q <= store_d;
      rdata_q <= rdata_d;
    end
  end
  assign ren = ren_q;
  assign wen = wen_q;
  assign ramaddr = addr_q;
  assign ramstore = store_q;
  assign busy = state_q != IDLE;
  assign ack = (state_q == RESP) ? (NREQ'(1) << win_q) : '0;
  // read data is only valid from the RAM during RESP; otherwise hold the last read
  assign rdata = (state_q == RESP && !wr_q) ? ramload : rdata_q;
endmodule

// File: tb/tb_syncram_arbiter.sv
// tb_syncram_arbiter: directed and randomized checks of syncram_arbiter with RAM_LAT=1 and RAM_LAT=3 instances
module tb_syncram_arbiter;
  logic clk = 1'b0;
  logic nRST;
  logic [1:0] req [2], rwen [2], ack [2];
  logic [63:0] raddr [2], rwd [2];
  logic [31:0] rdata [2], ramaddr [2], ramstore [2], ramload [2];
  logic busy [2], ren [2], wen [2];
  int n_vec = 0, n_err = 0, cyc = 0;
  logic [31:0] model_mem [2][64];
  int last_win [2], vfrom [2];
  logic [31:0] last_rd [2];
  logic [1:0] h_req [2][32], h_rw [2][32];
  logic [63:0] h_ad [2][32], h_wd [2][32];
  logic h_ren [2][32], h_wen [2][32], h_busy [2][32];
  logic [31:0] h_ra [2][32], h_rs [2][32];

  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(int a);
    return (a == 4) ? 32'h0000ABCD : 32'h1000_0000 + 32'(a) * 32'd7;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : gi
    logic [31:0] mem [64];
    logic [31:0] p0, p1, p2;
    initial for (int a = 0; a < 64; a++) mem[a] = init_val(a);
    syncram_arbiter #(.NREQ(2), .WORD_W(32), .RAM_LAT(g == 0 ? 1 : 3)) dut (
      .clk(clk), .nRST(nRST), .req(req[g]), .req_wen(rwen[g]), .req_addr(raddr[g]),
      .req_wdata(rwd[g]), .ack(ack[g]), .rdata(rdata[g]), .busy(busy[g]), .ren(ren[g]),
      .wen(wen[g]), .ramaddr(ramaddr[g]), .ramstore(ramstore[g]), .ramload(ramload[g]));
    always @(posedge clk) begin
      if (wen[g]) mem[ramaddr[g][5:0]] <= ramstore[g];
      p0 <= ren[g] ? mem[ramaddr[g][5:0]] : 32'hDEADBEEF;
      p1 <= p0;
      p2 <= p1;
    end
    assign ramload[g] = (g == 0) ? p0 : p2;
  end

  // Reference model: each ack is traced back to the cycle its grant was decided
  // (write: 2 cycles earlier, read: 1+RAM_LAT earlier) and checked against
  // round-robin order, the RAM command issued, and an array memory model.
  always @(negedge clk) begin : mon
    int s, d, ds, as, ex, lat, wi;
    logic wr;
    logic [31:0] a, wd, er;
    cyc++;
    for (int g = 0; g < 2; g++) begin
      s = cyc % 32;
      h_req[g][s] = req[g]; h_rw[g][s] = rwen[g]; h_ad[g][s] = raddr[g]; h_wd[g][s] = rwd[g];
      h_ren[g][s] = ren[g]; h_wen[g][s] = wen[g]; h_busy[g][s] = busy[g];
      h_ra[g][s] = ramaddr[g]; h_rs[g][s] = ramstore[g];
      if (!nRST) begin
        last_win[g] = 1; last_rd[g] = '0; vfrom[g] = cyc + 1;
      end else begin
        n_vec++;
        if ((ren[g] && wen[g]) || !$onehot0(ack[g])) begin
          n_err++;
          $display("FAIL excl g=%0d ren=%b wen=%b ack=%b, required ren&wen=0 and ack one-hot or zero", g, ren[g], wen[g], ack[g]);
        end
        if (ack[g] != 2'b00) begin
          wi = ack[g][1] ? 1 : 0;
          lat = (g == 0) ? 1 : 3;
          wr = h_rw[g][(cyc - 2) % 32][wi];
          d = wr ? cyc - 2 : cyc - 1 - lat;
          ds = d % 32; as = (d + 1) % 32;
          ex = -1;
          for (int k = 1; k <= 2; k++) if (ex < 0 && h_req[g][ds][(last_win[g] + k) % 2]) ex = (last_win[g] + k) % 2;
          a = h_ad[g][ds][wi*32 +: 32];
          wd = h_wd[g][ds][wi*32 +: 32];
          er = wr ? last_rd[g] : model_mem[g][a[5:0]];
          n_vec++;
          if (d < vfrom[g] || h_busy[g][ds] || ex != wi) begin
            n_err++;
            $display("FAIL grant g=%0d cyc=%0d got req%0d, required req%0d (pending=%b busy_at_decision=%b)", g, cyc, wi, ex, h_req[g][ds], h_busy[g][ds]);
          end
          n_vec++;
          if (h_ren[g][as] != !wr || h_wen[g][as] != wr || h_ra[g][as] !== a || (wr && h_rs[g][as] !== wd) || ren[g] || wen[g]) begin
            n_err++;
            $display("FAIL ramcmd g=%0d cyc=%0d ren=%b wen=%b addr=%h store=%h, required ren=%b wen=%b addr=%h store=%h", g, cyc, h_ren[g][as], h_wen[g][as], h_ra[g][as], h_rs[g][as], !wr, wr, a, wd);
          end
          n_vec++;
          if (rdata[g] !== er) begin
            n_err++;
            $display("FAIL rdata g=%0d cyc=%0d got %h, required %h", g, cyc, rdata[g], er);
          end
          if (wr) model_mem[g][a[5:0]] = wd;
          else last_rd[g] = er;
          last_win[g] = wi;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    for (int g = 0; g < 2; g++) begin
      req[g] = 2'b11; rwen[g] = 2'b01; raddr[g] = {32'd9, 32'd7}; rwd[g] = {32'h1234, 32'h5678};
    end
    repeat (4) begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        n_vec++;
        if (ren[g] || wen[g] || ack[g] != 0 || busy[g] || ramaddr[g] != 0 || ramstore[g] != 0 || rdata[g] != 0) begin
          n_err++;
          $display("FAIL reset g=%0d ren=%b wen=%b ack=%b busy=%b ramaddr=%h ramstore=%h rdata=%h, required all zero", g, ren[g], wen[g], ack[g], busy[g], ramaddr[g], ramstore[g], rdata[g]);
        end
      end
    end
    step();
    for (int g = 0; g < 2; g++) req[g] = 2'b00;
    nRST = 1'b1;
  endtask

  task automatic test_write_read();
    step();
    req[0] = 2'b01; rwen[0] = 2'b01; raddr[0][31:0] = 32'd3; rwd[0][31:0] = 32'd555;
    repeat (2) @(negedge clk);
    n_vec++;
    if (!(wen[0] && !ren[0] && ramaddr[0] == 32'd3 && ramstore[0] == 32'd555 && ack[0] == 2'b00)) begin
      n_err++;
      $display("FAIL wr_access wen=%b ren=%b addr=%0d store=%0d ack=%b, required wen=1 ren=0 addr=3 store=555 ack=00", wen[0], ren[0], ramaddr[0], ramstore[0], ack[0]);
    end
    @(negedge clk);
    n_vec++;
    if (ack[0] != 2'b01 || wen[0]) begin
      n_err++;
      $display("FAIL wr_ack ack=%b wen=%b, required ack=01 wen=0", ack[0], wen[0]);
    end
    step();
    rwen[0] = 2'b00;
    repeat (2) @(negedge clk);
    n_vec++;
    if (!(ren[0] && !wen[0] && ramaddr[0] == 32'd3)) begin
      n_err++;
      $display("FAIL rd_access ren=%b wen=%b addr=%0d, required ren=1 wen=0 addr=3", ren[0], wen[0], ramaddr[0]);
    end
    @(negedge clk);
    n_vec++;
    if (ack[0] != 2'b01 || rdata[0] != 32'd555) begin
      n_err++;
      $display("FAIL rd_ack ack=%b rdata=%0d, required ack=01 rdata=555", ack[0], rdata[0]);
    end
    step();
    req[0] = 2'b00;
  endtask

  task automatic test_contention();
    int nacks = 0;
    int w [2] = '{-1, -1};
    int t [2] = '{-1, -1};
    logic [31:0] ad [2] = '{32'd0, 32'd0};
    logic [1:0] seen;
    nRST = 1'b0;
    req[0] = 2'b11; rwen[0] = 2'b00; raddr[0] = {32'd2, 32'd1};
    step();
    nRST = 1'b1;
    for (int k = 0; k < 20 && nacks < 2; k++) begin
      @(negedge clk);
      seen = ack[0];
      if (seen != 2'b00) begin
        w[nacks] = seen[1] ? 1 : 0; ad[nacks] = ramaddr[0]; t[nacks] = k; nacks++;
      end
      step();
      req[0] = req[0] & ~seen;
    end
    n_vec++;
    if (nacks != 2 || w[0] != 0 || w[1] != 1) begin
      n_err++;
      $display("FAIL contention_order acks=%0d winners=%0d,%0d, required 2 acks winners 0,1", nacks, w[0], w[1]);
    end
    n_vec++;
    if (ad[0] != 32'd1 || ad[1] != 32'd2 || t[1] - t[0] != 3) begin
      n_err++;
      $display("FAIL contention_addr addrs=%0d,%0d spacing=%0d, required addrs 1,2 spacing 3", ad[0], ad[1], t[1] - t[0]);
    end
  endtask

  task automatic test_fairness();
    int n = 0;
    int w [8];
    logic [31:0] a [8];
    logic [1:0] seen;
    for (int j = 0; j < 8; j++) begin w[j] = -1; a[j] = '0; end
    req[0] = 2'b11; raddr[0] = {32'd9, 32'd8};
    rwen[0] = 2'($urandom_range(0, 3)); rwd[0] = {$urandom, $urandom};
    for (int k = 0; k < 80 && n < 8; k++) begin
      @(negedge clk);
      seen = ack[0];
      if (seen != 2'b00) begin
        w[n] = seen[1] ? 1 : 0; a[n] = ramaddr[0]; n++;
      end
      step();
      for (int i = 0; i < 2; i++) if (seen[i]) begin
        rwen[0][i] = 1'($urandom_range(0, 1)); rwd[0][i*32 +: 32] = $urandom;
      end
    end
    req[0] = 2'b00;
    for (int j = 0; j < 8; j++) begin
      n_vec++;
      if (w[j] != j % 2 || a[j] != 32'(8 + j % 2)) begin
        n_err++;
        $display("FAIL fairness grant%0d winner=%0d addr=%0d, required winner=%0d addr=%0d", j, w[j], a[j], j % 2, 8 + j % 2);
      end
    end
  endtask

  task automatic test_latency();
    int nren = 0, tack = -1;
    logic [31:0] rd = '0;
    logic [1:0] ak = '0;
    step();
    req[1] = 2'b01; rwen[1] = 2'b00; raddr[1][31:0] = 32'd4;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (ren[1]) nren++;
      if (ack[1] != 2'b00 && tack < 0) begin tack = k; rd = rdata[1]; ak = ack[1]; end
      step();
      if (tack == k) req[1] = 2'b00;
    end
    n_vec++;
    if (nren != 1 || tack != 4) begin
      n_err++;
      $display("FAIL latency ren_cycles=%0d ack_cycle=%0d, required ren_cycles=1 ack_cycle=4", nren, tack);
    end
    n_vec++;
    if (ak != 2'b01 || rd != 32'h0000ABCD) begin
      n_err++;
      $display("FAIL latency_data ack=%b rdata=%h, required ack=01 rdata=0000abcd", ak, rd);
    end
  endtask

  task automatic test_midop_reset();
    int nack = 0, tk = -1;
    logic [1:0] first = '0;
    step();
    req[1] = 2'b01; rwen[1] = 2'b00; raddr[1] = {32'd6, 32'd5};
    repeat (3) @(negedge clk);
    #1;
    nRST = 1'b0;
    req[1] = 2'b10;
    #1;
    n_vec++;
    if (busy[1] || ren[1] || wen[1] || ack[1] != 2'b00) begin
      n_err++;
      $display("FAIL midop_abort busy=%b ren=%b wen=%b ack=%b, required all zero", busy[1], ren[1], wen[1], ack[1]);
    end
    step();
    step();
    nRST = 1'b1;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (ack[1] != 2'b00) begin
        nack++;
        if (tk < 0) begin tk = k; first = ack[1]; end
      end
      step();
      if (tk == k) req[1] = 2'b00;
    end
    n_vec++;
    if (nack != 1 || first != 2'b10 || tk != 4) begin
      n_err++;
      $display("FAIL midop_regrant acks=%0d first=%b at=%0d, required acks=1 first=10 at=4", nack, first, tk);
    end
  endtask

  task automatic test_random();
    int wt [2][2];
    logic [1:0] seen [2];
    for (int g = 0; g < 2; g++) for (int i = 0; i < 2; i++) wt[g][i] = 0;
    for (int t = 0; t < 500; t++) begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) seen[g] = ack[g];
      step();
      for (int g = 0; g < 2; g++) for (int i = 0; i < 2; i++) begin
        if (seen[g][i]) begin
          n_vec++;
          if (wt[g][i] > 16) begin
            n_err++;
            $display("FAIL wait_bound g=%0d req%0d waited %0d cycles, required at most 16", g, i, wt[g][i]);
          end
          wt[g][i] = 0;
          if ($urandom_range(0, 1) == 1) begin
            rwen[g][i] = 1'($urandom_range(0, 1)); raddr[g][i*32 +: 32] = $urandom_range(0, 15); rwd[g][i*32 +: 32] = $urandom;
          end else req[g][i] = 1'b0;
        end else if (req[g][i]) begin
          wt[g][i]++;
          if (wt[g][i] > 40) begin
            n_vec++; n_err++;
            $display("FAIL timeout g=%0d req%0d no ack after %0d cycles, required ack", g, i, wt[g][i]);
            req[g][i] = 1'b0; wt[g][i] = 0;
          end
        end else if ($urandom_range(0, 3) == 0) begin
          req[g][i] = 1'b1; wt[g][i] = 0;
          rwen[g][i] = 1'($urandom_range(0, 1)); raddr[g][i*32 +: 32] = $urandom_range(0, 15); rwd[g][i*32 +: 32] = $urandom;
        end
      end
    end
  endtask

  initial begin
    nRST = 1'b0;
    for (int g = 0; g < 2; g++) begin
      req[g] = '0; rwen[g] = '0; raddr[g] = '0; rwd[g] = '0;
      for (int a = 0; a < 64; a++) model_mem[g][a] = init_val(a);
    end
    test_reset();
    test_write_read();
    test_contention();
    test_fairness();
    test_latency();
    test_midop_reset();
    test_random();
    for (int g = 0; g < 2; g++) req[g] = 2'b00;
    repeat (12) step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation exceeded time limit, required completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/syncram_arbiter.md
Name: syncram_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one single-port synchronous RAM (ren/wen/ramaddr/ramstore/ramload interface, word_t data) between NREQ requesters, e.g. the scalar functional unit and a loader.
- Serialises accesses, drives registered RAM controls, waits out the RAM read latency, and returns one ack pulse per access, with read data where applicable.
- Sits between the requesting units and the syncram instance.

Parameters:
NREQ, 2, number of requesters (2..8)
WORD_W, 32, data/address width (word_t)
RAM_LAT, 1, RAM read latency in cycles from the ren-sampling edge to valid ramload (1..4)

Ports:
clk  in  1  clock, rising edge
nRST  in  1  asynchronous active-low reset
req  in  NREQ  per-requester request; held high with its attributes until the matching ack
req_wen  in  NREQ  per-requester write (1) / read (0) select
req_addr  in  NREQ*WORD_W  per-requester address; slice i = [i*WORD_W +: WORD_W]
req_wdata  in  NREQ*WORD_W  per-requester write data, same slicing
ack  out  NREQ  one-hot, one-cycle completion pulse
rdata  out  WORD_W  read data; valid only while ack is asserted for a read
busy  out  1  high in every state except IDLE
ren  out  1  RAM read enable (registered)
wen  out  1  RAM write enable (registered)
ramaddr  out  WORD_W  RAM address (registered)
ramstore  out  WORD_W  RAM write data (registered)
ramload  in  WORD_W  RAM read data

Behaviour:
- Reset (async, nRST=0): state=IDLE; ren=wen=0; ramaddr=ramstore=0; ack=0; rdata=0; busy=0; rr_ptr=NREQ-1, so requester 0 has top priority first; lat_cnt=0.
- Reset asserted mid-access aborts the access. No ack is issued. Requesters re-request after reset.
- FSM states: IDLE, ACCESS, WAIT, RESP.
- IDLE:
  - If req!=0, pick the winner by round-robin: search from (rr_ptr+1) mod NREQ upward, wrapping; first set bit wins.
  - Register win_idx.
  - Load ramaddr, and ramstore if writing, from the winner's slice.
  - Set ren=~req_wen[win] and wen=req_wen[win].
  - Go to ACCESS.
- ACCESS (exactly one cycle, ren or wen high):
  - At the exit edge, clear ren/wen.
  - Write: go to RESP.
  - Read with RAM_LAT=1: go to RESP.
  - Read with RAM_LAT>1: lat_cnt=RAM_LAT-1, go to WAIT.
- WAIT: decrement lat_cnt each cycle; when lat_cnt==1 at the edge, go to RESP. ren/wen stay 0.
- RESP (one cycle):
  - ack[win_idx]=1.
  - For reads, rdata = ramload, which is valid in this cycle; for writes, rdata holds its last value.
  - rr_ptr<=win_idx.
  - Go to IDLE unconditionally.
- Per-access latency:
  - Write: 3 cycles, req seen in IDLE to ack.
  - Read: 2+RAM_LAT cycles.
  - Minimum spacing between accesses is 3 cycles.
- Requesters must drop req, or present a new request, in the cycle after ack. A req still high in IDLE after ack is treated as a new request.
- The arbiter samples req only in IDLE. Changes to req or attributes outside IDLE are ignored except for the current winner. The winner's attributes are already registered, so its later changes are also ignored.
- Simultaneous requests: exactly one winner. The others stay pending and are served in round-robin order. No requester waits more than NREQ-1 other accesses.
- Output rules:
  - ack, ren, wen, ramaddr, ramstore and rdata are all registered or state-decoded; none is combinational from req.
  - ack is never asserted for more than one requester.
  - ren and wen are never both 1.
- Read-after-write to the same address from different requesters returns the new data, because accesses are strictly serialised.

Test Plan:
- Reset: hold nRST=0 with req=2'b11 -> ren=wen=0, ack=0, busy=0, ramaddr=0 throughout.
- Single write then read, RAM_LAT=1:
  - Req0 write addr=3, wdata=555 -> wen=1, ramaddr=3, ramstore=555 for exactly 1 cycle; ack[0] 2 cycles later.
  - Req0 then reads addr=3 -> ack[0] with rdata=555, 3 cycles after req.
- Contention: req=2'b11 from reset, both reads (addr 1, 2) -> req0 served first (ramaddr=1), then req1 (ramaddr=2); acks 3 cycles apart; never simultaneous.
- Fairness: req0 and req1 held continuously for 8 accesses -> grants alternate 0,1,0,1,…; RAM address sequence alternates.
- Latency: RAM_LAT=3, read addr=4 (RAM preloaded 0xABCD) -> ren high 1 cycle; ack 5 cycles after req, with rdata=0xABCD.
- Mid-op reset: assert nRST=0 during WAIT/ACCESS of a read -> immediate IDLE, no ack; after release, a pending req1 is granted first (rr_ptr reset).
